poke_grid_select_ctrl: RTL and testbench



---
 rtl/poke_grid_select_ctrl.sv | 128 ++++++++++++
 tb/tb_poke_grid_select_ctrl.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/poke_grid_select_ctrl.sv
// poke_grid_select_ctrl: two-player ROWS x COLS cursor grid with per-player confirm and stat ROM fetch.
// Optional macro WRAP_CURSOR_EN: when defined, cursor moves past a grid edge wrap to the opposite edge.
module poke_grid_select_ctrl #(
  parameter int COLS = 4,
  parameter int ROWS = 2,
  parameter int ID_W = 8,
  parameter int STAT_W = 8,
  parameter logic [3:0] CHOOSE_SCENE = 4'b0010,
  parameter logic [3:0] START_SCENE = 4'b0001
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [3:0]          scene_state,
  input  logic                key_U,
  input  logic                key_D,
  input  logic                key_L,
  input  logic                key_R,
  input  logic                key_C,
  output logic [ID_W-1:0]     cursor_id,
  output logic                active_player,
  output logic                rom_en,
  output logic [ID_W-1:0]     rom_addr,
  input  logic [5*STAT_W-1:0] rom_data,
  output logic [ID_W-1:0]     p1_id,
  output logic [ID_W-1:0]     p2_id,
  output logic [5*STAT_W-1:0] p1_stats,
  output logic [5*STAT_W-1:0] p2_stats,
  output logic                sel_done
);
  typedef enum logic [2:0] {IDLE, P1_SEL, P1_LOAD, P2_SEL, P2_LOAD, DONE} state_t;
  state_t r_state, w_state_n;
  logic [3:0] r_row, r_col, w_row_n, w_col_n;
  logic [3:0] w_up, w_dn, w_lf, w_rt;
  logic [ID_W-1:0] r_p1_id, r_p2_id, r_rom_addr, w_p1_id_n, w_p2_id_n, w_rom_addr_n, w_cursor;
  logic [5*STAT_W-1:0] r_p1_stats, r_p2_stats, w_p1_stats_n, w_p2_stats_n;
  logic w_nav;
  // The cursor position is held as row/col so edge tests are direct; the id is derived row-major.
  assign w_cursor = ID_W'(r_row) * ID_W'(COLS) + ID_W'(r_col) + ID_W'(1);
  assign w_nav = (scene_state == CHOOSE_SCENE) && $onehot({key_U, key_D, key_L, key_R, key_C});
`ifdef WRAP_CURSOR_EN
  assign w_up = (r_row == 4'd0) ? 4'(ROWS - 1) : r_row - 4'd1;
  assign w_dn = (r_row == 4'(ROWS - 1)) ? 4'd0 : r_row + 4'd1;
  assign w_lf = (r_col == 4'd0) ? 4'(COLS - 1) : r_col - 4'd1;
  assign w_rt = (r_col == 4'(COLS - 1)) ? 4'd0 : r_col + 4'd1;
`else
  assign w_up = (r_row == 4'd0) ? r_row : r_row - 4'd1;
  assign w_dn = (r_row == 4'(ROWS - 1)) ? r_row : r_row + 4'd1;
  assign w_lf = (r_col == 4'd0) ? r_col : r_col - 4'd1;
  assign w_rt = (r_col == 4'(COLS - 1)) ? r_col : r_col + 4'd1;
`endif
  // Next-state logic; START_SCENE aborts any sequence and discards a pending ROM result.
  always_comb begin
    w_state_n = r_state;
    w_row_n = r_row;
    w_col_n = r_col;
    w_p1_id_n = r_p1_id;
    w_p2_id_n = r_p2_id;
    w_p1_stats_n = r_p1_stats;
    w_p2_stats_n = r_p2_stats;
    w_rom_addr_n = r_rom_addr;
    if (scene_state == START_SCENE)
      w_state_n = IDLE;
    else
      case (r_state)
        IDLE: if (scene_state == CHOOSE_SCENE) begin
          w_state_n = P1_SEL;
          w_row_n = '0;
          w_col_n = '0;
          w_p1_id_n = '0;
          w_p2_id_n = '0;
          w_p1_stats_n = '0;
          w_p2_stats_n = '0;
        end
        P1_SEL, P2_SEL: if (w_nav) begin
          if (key_C) begin
            w_state_n = (r_state == P1_SEL) ? P1_LOAD : P2_LOAD;
            w_p1_id_n = (r_state == P1_SEL) ? w_cursor : r_p1_id;
            w_p2_id_n = (r_state == P2_SEL) ? w_cursor : r_p2_id;
            w_rom_addr_n = w_cursor - ID_W'(1);
          end else begin
            w_row_n = key_U ? w_up : key_D ? w_dn : r_row;
            w_col_n = key_L ? w_lf : key_R ? w_rt : r_col;
          end
        end
        P1_LOAD: begin
          w_p1_stats_n = rom_data;
          w_state_n = P2_SEL;
        end
        P2_LOAD: begin
          w_p2_stats_n = rom_data;
          w_state_n = DONE;
        end
        default: ;
      endcase
  end
  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_row <= '0;
      r_col <= '0;
      r_p1_id <= '0;
      r_p2_id <= '0;
      r_p1_stats <= '0;
      r_p2_stats <= '0;
      r_rom_addr <= '0;
    end else begin
      r_state <= w_state_n;
      r_row <= w_row_n;
      r_col <= w_col_n;
      r_p1_id <= w_p1_id_n;
      r_p2_id <= w_p2_id_n;
      r_p1_stats <= w_p1_stats_n;
      r_p2_stats <= w_p2_stats_n;
      r_rom_addr <= w_rom_addr_n;
    end
  end
  // The ROM strobe is exactly the one load cycle that follows a confirm.
  assign rom_en = (r_state == P1_LOAD) || (r_state == P2_LOAD);
  assign active_player = (r_state == P2_SEL) || (r_state == P2_LOAD) || (r_state == DONE);
  assign sel_done = (r_state == DONE);
  assign cursor_id = w_cursor;
  assign rom_addr = r_rom_addr;
  assign p1_id = r_p1_id;
  assign p2_id = r_p2_id;
  assign p1_stats = r_p1_stats;
  assign p2_stats = r_p2_stats;
endmodule

// File: tb/tb_poke_grid_select_ctrl.sv
// tb_poke_grid_select_ctrl: scoreboard bench for the grid select controller (default and 3x5 instances).
module tb_poke_grid_select_ctrl;
  logic clk = 0;
  logic reset, reset2;
  logic [3:0] scene, scene2;
  logic [4:0] k, k2;
  logic [7:0] cursor, rom_addr, p1_id, p2_id, cursor2, rom_addr2, p1_id2, p2_id2;
  logic [39:0] rom_data, p1_stats, p2_stats, rom_data2, p1_stats2, p2_stats2;
  logic active, rom_en, sel_done, active2, rom_en2, sel_done2;
  int errs = 0, checks = 0;
  localparam logic [3:0] CHOOSE = 4'b0010, START = 4'b0001, FIGHT = 4'b0100;
  localparam logic [4:0] KU = 5'b10000, KD = 5'b01000, KL = 5'b00100, KR = 5'b00010, KC = 5'b00001;
  always #5 clk = ~clk;
  function automatic logic [39:0] rom_f(logic [7:0] a);
    return (a == 8'd1) ? 40'h642C1E2832 : {a + 8'h10, a + 8'h20, a + 8'h30, a + 8'h40, a + 8'h50};
  endfunction
  assign rom_data = rom_f(rom_addr);
  assign rom_data2 = rom_f(rom_addr2);
  poke_grid_select_ctrl u_dut (
    .clk(clk), .reset(reset), .scene_state(scene),
    .key_U(k[4]), .key_D(k[3]), .key_L(k[2]), .key_R(k[1]), .key_C(k[0]),
    .cursor_id(cursor), .active_player(active), .rom_en(rom_en), .rom_addr(rom_addr),
    .rom_data(rom_data), .p1_id(p1_id), .p2_id(p2_id), .p1_stats(p1_stats),
    .p2_stats(p2_stats), .sel_done(sel_done)
  );
  poke_grid_select_ctrl #(.ROWS(3), .COLS(5)) u_dut2 (
    .clk(clk), .reset(reset2), .scene_state(scene2),
    .key_U(k2[4]), .key_D(k2[3]), .key_L(k2[2]), .key_R(k2[1]), .key_C(k2[0]),
    .cursor_id(cursor2), .active_player(active2), .rom_en(rom_en2), .rom_addr(rom_addr2),
    .rom_data(rom_data2), .p1_id(p1_id2), .p2_id(p2_id2), .p1_stats(p1_stats2),
    .p2_stats(p2_stats2), .sel_done(sel_done2)
  );
  task automatic chk(string n, logic [63:0] a, logic [63:0] e);
    checks++;
    if (a !== e) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask
  typedef struct {logic [7:0] addr; logic pl; logic [7:0] id; logic [39:0] st;} ld_t;
  typedef struct {logic [7:0] i1, i2; logic [39:0] s1, s2;} dn_t;
  ld_t ldq[$];
  dn_t dnq[$];
  ld_t cur;
  dn_t dn;
  bit pend = 0, prev_done = 0;
  always @(negedge clk) begin
    if (pend) begin
      chk("stats", cur.pl ? p2_stats : p1_stats, cur.st);
      pend = 0;
    end
    if (rom_en) begin
      if (ldq.size() == 0) chk("rom_en_unexpected", 1, 0);
      else begin
        cur = ldq.pop_front();
        chk("rom_addr", rom_addr, cur.addr);
        chk("load_player", active, cur.pl);
        chk("conf_id", cur.pl ? p2_id : p1_id, cur.id);
        pend = 1;
      end
    end
    if (sel_done && !prev_done) begin
      if (dnq.size() == 0) chk("done_unexpected", 1, 0);
      else begin
        dn = dnq.pop_front();
        chk("done_p1_id", p1_id, dn.i1);
        chk("done_p2_id", p2_id, dn.i2);
        chk("done_p1_stats", p1_stats, dn.s1);
        chk("done_p2_stats", p2_stats, dn.s2);
      end
    end
    prev_done = sel_done;
  end
  task automatic press(logic [4:0] keys);
    k = keys;
    @(negedge clk);
    k = '0;
  endtask
  task automatic press2(logic [4:0] keys);
    k2 = keys;
    @(negedge clk);
    k2 = '0;
  endtask
  initial begin
    logic [7:0] e_u, e_l;
`ifdef WRAP_CURSOR_EN
    e_u = 8'd5; e_l = 8'd8;
`else
    e_u = 8'd1; e_l = 8'd1;
`endif
    reset = 1; reset2 = 1; scene = '0; scene2 = '0; k = '0; k2 = '0;
    repeat (3) @(negedge clk);
    reset = 0;
    chk("rst_cursor", cursor, 1);
    chk("rst_active", active, 0);
    chk("rst_rom_en", rom_en, 0);
    chk("rst_rom_addr", rom_addr, 0);
    chk("rst_ids", {p1_id, p2_id}, 0);
    chk("rst_stats", p1_stats | p2_stats, 0);
    chk("rst_done", sel_done, 0);
    scene = CHOOSE;
    @(negedge clk);
    chk("p1_cursor0", cursor, 1);
    press(KR); chk("cursor_R1", cursor, 2);
    press(KR); chk("cursor_R2", cursor, 3);
    press(KD); chk("cursor_D", cursor, 7);
    ldq.push_back('{8'd6, 1'b0, 8'd7, 40'h1626364656});
    press(KC);
    press(KR);
    chk("load_keys_ignored", cursor, 7);
    chk("p2_active", active, 1);
    press(KL); chk("p2_cursor_L", cursor, 6);
    press(KU); chk("p2_cursor_U", cursor, 2);
    ldq.push_back('{8'd1, 1'b1, 8'd2, 40'h642C1E2832});
    dnq.push_back('{8'd7, 8'd2, 40'h1626364656, 40'h642C1E2832});
    press(KC);
    scene = FIGHT;
    press(KR);
    press(KC);
    press(KL);
    repeat (2) @(negedge clk);
    chk("done_held", sel_done, 1);
    chk("done_cursor", cursor, 2);
    chk("done_ids", {p1_id, p2_id}, {8'd7, 8'd2});
    chk("done_p2_stats_held", p2_stats, 40'h642C1E2832);
    scene = START;
    @(negedge clk);
    chk("start_done_clr", sel_done, 0);
    chk("start_ids_kept", {p1_id, p2_id}, {8'd7, 8'd2});
    scene = CHOOSE;
    @(negedge clk);
    chk("reenter_cursor", cursor, 1);
    chk("reenter_ids", {p1_id, p2_id}, 0);
    chk("reenter_stats", p1_stats | p2_stats, 0);
    press(KU); chk("edge_U", cursor, e_u);
    press(KL); chk("edge_L", cursor, e_l);
    press(KU | KR); chk("multi_key", cursor, e_l);
`ifdef WRAP_CURSOR_EN
    press(KR); chk("wrap_R", cursor, 5);
    press(KL); chk("wrap_L", cursor, 8);
`else
    press(KD); press(KR); press(KR); press(KR);
    chk("nav_to_8", cursor, 8);
    press(KR); chk("edge_R", cursor, 8);
    press(KD); chk("edge_D", cursor, 8);
`endif
    ldq.push_back('{8'd7, 1'b0, 8'd8, 40'h1727374757});
    press(KC);
    @(negedge clk);
    chk("p2_sel_active", active, 1);
    scene = FIGHT;
    press(KL);
    chk("sel_scene_hold", cursor, 8);
    chk("sel_scene_hold_act", active, 1);
    scene = START;
    @(negedge clk);
    chk("abort_active", active, 0);
    chk("abort_done", sel_done, 0);
    chk("abort_p1_kept", p1_id, 8);
    scene = CHOOSE;
    @(negedge clk);
    chk("abort_reenter_cursor", cursor, 1);
    chk("abort_reenter_p1", p1_id, 0);
    chk("abort_reenter_stats", p1_stats, 0);
    reset2 = 0; scene2 = CHOOSE;
    @(negedge clk);
    press2(KD); press2(KD);
    chk("g35_cursor_DD", cursor2, 11);
    press2(KR); press2(KR); press2(KR); press2(KR);
    chk("g35_cursor", cursor2, 15);
    press2(KC);
    chk("g35_rom_en", rom_en2, 1);
    chk("g35_rom_addr", rom_addr2, 14);
    chk("g35_p1_id", p1_id2, 15);
    reset2 = 1;
    @(negedge clk);
    chk("g35_rst_cursor", cursor2, 1);
    chk("g35_rst_rom", {rom_en2, rom_addr2}, 0);
    chk("g35_rst_ids", {p1_id2, p2_id2}, 0);
    chk("g35_rst_stats", p1_stats2 | p2_stats2, 0);
    chk("g35_rst_flags", {active2, sel_done2}, 0);
    repeat (2) @(negedge clk);
    chk("ldq_empty", ldq.size(), 0);
    chk("dnq_empty", dnq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
